serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter. It is the driving end of the single-wire serial link whose receiving end is a D-flip-flop sampler/deserializer.
- Accepts a DATA_W-bit word on a ready/start handshake.
- Emits one frame on SerOut: start bit (0), data LSB-first, optional even-parity bit, stop bit (1).
- Holds each bit for BIT_CYCLES clocks, so the receiving flip-flops sample mid-bit.

Parameters:
DATA_W, 8, data bits per frame (1..16)
BIT_CYCLES, 4, clocks each bit is held on SerOut (>=1)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
Clock  input  1  rising-edge clock; all state changes on its rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request to send; accepted only on an edge where Ready=1
DataIn  input  DATA_W  word to send; sampled on the accepting edge only
Ready  output  1  1 = idle and able to accept Start
SerOut  output  1  serial line; idles high
Done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset (sampled on the Clock rising edge while Reset=1):
  - Outputs go to Ready=1, SerOut=1, Done=0.
  - FSM goes to IDLE. Shift register, bit counter and cycle counter clear to 0.
  - Reset overrides Start and any frame in progress.
  - Outputs hold these values for as long as Reset stays high.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - Ready=1, SerOut=1.
  - On an edge with Start=1: latch DataIn into the shift register, compute parity = XOR of DataIn, clear counters, go to START.
  - On the next cycle SerOut=0 and Ready=0.
- Cycle counter: runs 0..BIT_CYCLES-1 within each bit. At the terminal count it resets to 0 and the FSM advances to the next bit or state.
- START: SerOut=0 for BIT_CYCLES clocks, then go to DATA.
- DATA:
  - SerOut = shift-register bit 0.
  - At each bit end, shift right by 1 and increment the bit counter.
  - After DATA_W bits, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: SerOut = latched parity bit, so the total count of ones across data plus parity is even. Held BIT_CYCLES clocks, then go to STOP.
- STOP: SerOut=1 for BIT_CYCLES clocks. At the final edge go to IDLE with Ready=1 and Done=1 for exactly one cycle.
- Frame length: the first SerOut=0 cycle to the last stop cycle is (DATA_W+PARITY_EN+2)*BIT_CYCLES clocks. Done asserts in the cycle immediately after that.
- Start while Ready=0 is ignored. Nothing is queued and the frame in flight is unaffected.
- DataIn changes after the accepting edge have no effect on the frame in flight.
- Back-to-back frames: Start=1 during the Done cycle (Ready=1) is accepted. The next START bit begins the following cycle, with no extra idle bit.
- Reset mid-frame: on the next edge SerOut=1, Ready=1 and no Done pulse is generated. The aborted frame is not resumed.
- BIT_CYCLES=1: one bit per clock, same state sequence.

Test Plan:
1. Reset held 3 cycles, Start=1 throughout -> Ready=1, SerOut=1, Done=0 on every cycle; no frame starts until Reset=0.
2. Defaults, DataIn=8'hA5, one-cycle Start -> SerOut bits (4 clocks each): 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1. That is 44 clocks; Ready=0 throughout; Done=1 on clock 45 only, then Ready=1.
3. DataIn=8'h07 with PARITY_EN=1 -> parity bit=1. Same word with PARITY_EN=0 -> no parity slot, 40-clock frame.
4. Start pulses and DataIn changed to 8'hFF mid-frame of 8'h3C -> ignored. Line carries 8'h3C LSB-first and exactly one Done pulse.
5. Start=1 during the Done cycle with DataIn=8'h81 -> the next start bit (0) appears on the following cycle, and the second frame transmits 8'h81 correctly.
6. Reset asserted for 1 cycle during the DATA state of 8'h55 -> next cycle SerOut=1, Ready=1, no Done pulse. A subsequent Start sends a complete fresh frame.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Parallel-in, serial-out frame transmitter. A word accepted on the
// Ready/Start handshake goes out on SerOut as one frame:
//    start bit (0), data LSB-first, optional even-parity bit, stop bit (1).
// Each bit is held for BIT_CYCLES clocks, so the receiving sampler can
// pick it up mid-bit.
//
// Ports
//    Clock   rising-edge clock
//    Reset   synchronous, active-high reset
//    Start   send request, taken only on an edge where Ready=1
//    DataIn  word to send, sampled on the accepting edge only
//    Ready   1 = idle and able to accept Start
//    SerOut  serial line, idles high
//    Done    one-cycle pulse in the cycle after the stop bit
//
// state  | meaning
// IDLE   | line high, Ready=1, waiting for Start
// START  | start bit (0) on the line
// DATA   | data bits, LSB first, one per BIT_CYCLES clocks
// PARITY | even-parity bit (only visited when PARITY_EN=1)
// STOP   | stop bit (1); the last edge returns to IDLE and pulses Done
module serial_frame_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4,
   parameter int PARITY_EN  = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [DATA_W-1:0] DataIn,
   output logic              Ready,
   output logic              SerOut,
   output logic              Done
);

   localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic [CYC_W-1:0]  cyc_cnt, cyc_nx;
   logic [BIT_W-1:0]  bit_cnt, bit_nx;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic              par_bit, par_nx;
   logic              ready_nx, ser_nx, done_nx;
   logic              bit_end;

   assign bit_end = (cyc_cnt == CYC_LAST);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         Ready   <= 1'b1;
         SerOut  <= 1'b1;
         Done    <= 1'b0;
      end else begin
         state   <= state_nx;
         cyc_cnt <= cyc_nx;
         bit_cnt <= bit_nx;
         shreg   <= shreg_nx;
         par_bit <= par_nx;
         Ready   <= ready_nx;
         SerOut  <= ser_nx;
         Done    <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cyc_nx   = cyc_cnt;
      bit_nx   = bit_cnt;
      shreg_nx = shreg;
      par_nx   = par_bit;
      done_nx  = 1'b0;

      // The cycle counter only runs while a bit is on the line.
      if (state != IDLE) begin
         cyc_nx = bit_end ? '0 : cyc_cnt + CYC_W'(1);
      end

      case (state)
         IDLE: begin
            if (Start) begin
               shreg_nx = DataIn;
               par_nx   = ^DataIn;
               cyc_nx   = '0;
               bit_nx   = '0;
               state_nx = START;
            end
         end
         START: begin
            if (bit_end) state_nx = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shreg_nx = shreg >> 1;
               bit_nx   = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_LAST) begin
                  state_nx = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_nx = STOP;
         end
         STOP: begin
            if (bit_end) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered, so they are decoded from the next state and
   // the next shift-register contents.
   always_comb begin
      ready_nx = 1'b0;
      ser_nx   = 1'b1;
      case (state_nx)
         IDLE:    ready_nx = 1'b1;
         START:   ser_nx   = 1'b0;
         DATA:    ser_nx   = shreg_nx[0];
         PARITY:  ser_nx   = par_nx;
         STOP:    ser_nx   = 1'b1;
         default: ser_nx   = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

   localparam int BC = 4;

   logic       Clock;
   logic       rst;
   logic       sel;
   logic       start_v;
   logic [7:0] data_v;

   logic start_a, ready_a, ser_a, done_a;
   logic start_b, ready_b, ser_b, done_b;
   logic ready_s, ser_s, done_s;

   int total = 0;
   int bad   = 0;

   assign start_a = start_v & ~sel;
   assign start_b = start_v & sel;
   assign ready_s = sel ? ready_b : ready_a;
   assign ser_s   = sel ? ser_b   : ser_a;
   assign done_s  = sel ? done_b  : done_a;

   serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(BC), .PARITY_EN(1)) dut (
      .Clock(Clock), .Reset(rst), .Start(start_a), .DataIn(data_v),
      .Ready(ready_a), .SerOut(ser_a), .Done(done_a)
   );

   serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(BC), .PARITY_EN(0)) dut_np (
      .Clock(Clock), .Reset(rst), .Start(start_b), .DataIn(data_v),
      .Ready(ready_b), .SerOut(ser_b), .Done(done_b)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Reference frame: list of line levels, one entry per clock.
   function automatic void build_frame(input logic [7:0] w, input bit par_en,
                                       output bit q[$]);
      bit bits[$];
      int ones;
      q = {};
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         bits.push_back(w[i]);
         if (w[i]) ones++;
      end
      if (par_en) bits.push_back((ones % 2) == 1);
      bits.push_back(1'b1);
      foreach (bits[k])
         for (int c = 0; c < BC; c++) q.push_back(bits[k]);
   endfunction

   // Caller sits at a negedge. If pre=1, Start/DataIn were already set in
   // the previous Done cycle. If chain=1, the next Start is issued in this
   // frame's Done cycle.
   task automatic run_frame(input logic [7:0] w, input bit pre, input bit noise,
                            input bit chain, input logic [7:0] nxt,
                            input string name);
      bit exp[$];
      build_frame(w, !sel, exp);
      if (!pre) begin
         start_v = 1'b1;
         data_v  = w;
      end
      for (int i = 0; i < exp.size(); i++) begin
         @(negedge Clock);
         if (i == 0) start_v = 1'b0;
         if (noise && i > 0) begin
            start_v = 1'($urandom_range(0, 1));
            data_v  = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
         end
         total++;
         if (ser_s !== exp[i] || ready_s !== 1'b0 || done_s !== 1'b0) begin
            bad++;
            $display("FAIL %s cycle %0d: ser=%b ready=%b done=%b, want ser=%b ready=0 done=0",
                     name, i, ser_s, ready_s, done_s, exp[i]);
         end
      end
      @(negedge Clock);
      total++;
      if (done_s !== 1'b1 || ready_s !== 1'b1 || ser_s !== 1'b1) begin
         bad++;
         $display("FAIL %s done cycle: done=%b ready=%b ser=%b, want 1 1 1",
                  name, done_s, ready_s, ser_s);
      end
      start_v = chain;
      if (chain) data_v = nxt;
      if (!chain) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            total++;
            if (done_s !== 1'b0 || ready_s !== 1'b1 || ser_s !== 1'b1) begin
               bad++;
               $display("FAIL %s idle after done %0d: done=%b ready=%b ser=%b, want 0 1 1",
                        name, i, done_s, ready_s, ser_s);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      start_v = 1'b1;
      data_v  = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         total++;
         if (ready_s !== 1'b1 || ser_s !== 1'b1 || done_s !== 1'b0) begin
            bad++;
            $display("FAIL reset cycle %0d: ready=%b ser=%b done=%b, want 1 1 0",
                     i, ready_s, ser_s, done_s);
         end
      end
      rst     = 1'b0;
      start_v = 1'b0;
      @(negedge Clock);
      total++;
      if (ready_s !== 1'b1 || ser_s !== 1'b1 || done_s !== 1'b0) begin
         bad++;
         $display("FAIL reset release: ready=%b ser=%b done=%b, want 1 1 0",
                  ready_s, ser_s, done_s);
      end
   endtask

   task automatic test_basic();
      sel = 1'b0;
      run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, "a5_frame");
   endtask

   task automatic test_parity();
      sel = 1'b0;
      run_frame(8'h07, 1'b0, 1'b0, 1'b0, 8'h00, "07_parity");
      sel = 1'b1;
      run_frame(8'h07, 1'b0, 1'b0, 1'b0, 8'h00, "07_noparity");
      sel = 1'b0;
   endtask

   task automatic test_ignore();
      sel = 1'b0;
      run_frame(8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, "3c_ignore_start");
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      sel = 1'b0;
      w = 8'($urandom);
      run_frame(w, 1'b0, 1'b0, 1'b1, 8'h81, "b2b_first");
      run_frame(8'h81, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_81");
      sel = 1'b1;
      run_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8'hC3, "b2b_np_first");
      run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_np_second");
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit exp[$];
      sel = 1'b0;
      build_frame(8'h55, 1'b1, exp);
      start_v = 1'b1;
      data_v  = 8'h55;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         start_v = 1'b0;
         total++;
         if (ser_s !== exp[i] || ready_s !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid pre cycle %0d: ser=%b ready=%b, want ser=%b ready=0",
                     i, ser_s, ready_s, exp[i]);
         end
      end
      rst = 1'b1;
      @(negedge Clock);
      rst = 1'b0;
      total++;
      if (ser_s !== 1'b1 || ready_s !== 1'b1 || done_s !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid abort: ser=%b ready=%b done=%b, want 1 1 0",
                  ser_s, ready_s, done_s);
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge Clock);
         total++;
         if (ser_s !== 1'b1 || ready_s !== 1'b1 || done_s !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid quiet cycle %0d: ser=%b ready=%b done=%b, want 1 1 0",
                     i, ser_s, ready_s, done_s);
         end
      end
      run_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 8'h00, "reset_mid_fresh");
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         sel = 1'($urandom_range(0, 1));
         run_frame(8'($urandom), 1'b0, (n % 2) == 1, 1'b0, 8'h00, "random");
      end
      sel = 1'b0;
   endtask

   initial begin
      sel     = 1'b0;
      rst     = 1'b1;
      start_v = 1'b0;
      data_v  = 8'h00;
      test_reset();
      test_basic();
      test_parity();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
